// File: rtl/key_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_enc_pkg
// Brief   : Shared FSM state type, default debounce depth and encode helpers
//           for the 4-to-2 key encoder.
// Revision: 1.0 - initial release
// ============================================================================
package key_enc_pkg;

    localparam int unsigned c_debounce_cycles_default = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } key_state_e;

    // Highest-numbered active line wins.
    function automatic logic [1:0] prio_enc4(input logic [3:0] keys);
        logic [1:0] idx;
        if (keys[3])      idx = 2'd3;
        else if (keys[2]) idx = 2'd2;
        else if (keys[1]) idx = 2'd1;
        else              idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] keys);
        return {2'b00, keys[0]} + {2'b00, keys[1]} + {2'b00, keys[2]} + {2'b00, keys[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// ============================================================================
// Module  : key_sync
// Brief   : Parameterized-width two-flop synchronizer, async active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
module key_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module  : key_encoder_4to2
// Brief   : Debounced 4-line key priority encoder with valid/ready handout
//           and a wrapping count of accepted codes.
// Revision: 1.0 - initial release
// ============================================================================
module key_encoder_4to2
    import key_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [1:0] code,
    output logic       multi,
    output logic [7:0] press_cnt
);

    localparam int unsigned          c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

    logic [3:0]         w_sync;

    key_state_e         r_state,     w_state_nxt;
    logic [3:0]         r_snapshot,  w_snapshot_nxt;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
    logic [1:0]         r_code,      w_code_nxt;
    logic               r_multi,     w_multi_nxt;
    logic [7:0]         r_press_cnt, w_press_cnt_nxt;

    key_sync #(
        .WIDTH (4)
    ) u_key_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (key_in),
        .o_sync  (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_snapshot  <= 4'b0000;
            r_cnt       <= '0;
            r_code      <= 2'd0;
            r_multi     <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_snapshot  <= w_snapshot_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code      <= w_code_nxt;
            r_multi     <= w_multi_nxt;
            r_press_cnt <= w_press_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_snapshot_nxt  = r_snapshot;
        w_cnt_nxt       = r_cnt;
        w_code_nxt      = r_code;
        w_multi_nxt     = r_multi;
        w_press_cnt_nxt = r_press_cnt;

        case (r_state)
            IDLE: begin
                if (w_sync != 4'b0000) begin
                    w_snapshot_nxt = w_sync;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (w_sync == 4'b0000) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_sync != r_snapshot) begin
                    // Pattern changed while bouncing: restart on the new pattern.
                    w_snapshot_nxt = w_sync;
                    w_cnt_nxt      = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_code_nxt  = prio_enc4(r_snapshot);
                    w_multi_nxt = (popcount4(r_snapshot) > 3'd1);
                    w_state_nxt = PRESENT;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            PRESENT: begin
                if (code_ready) begin
                    w_press_cnt_nxt = r_press_cnt + 8'd1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = RELEASE;
                end
            end
            RELEASE: begin
                // Any activity restarts the release window; all keys must be up.
                if (w_sync != 4'b0000) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign code_valid = (r_state == PRESENT);
    assign code       = r_code;
    assign multi      = r_multi;
    assign press_cnt  = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_encoder_4to2
// Brief   : Directed self-checking bench for key_encoder_4to2 (DEBOUNCE=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic       code_ready;
    logic       code_valid;
    logic [1:0] code;
    logic       multi;
    logic [7:0] press_cnt;

    int n_vec = 0;
    int n_err = 0;

    key_encoder_4to2 #(
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code       (code),
        .multi      (multi),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges until code_valid rises; returns max on timeout.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!code_valid && n < max) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        int exp_cnt;

        rst_n      = 1'b0;
        key_in     = 4'b0000;
        code_ready = 1'b0;
        #3;
        check("rst_valid", code_valid, 0);
        check("rst_code",  code,       0);
        check("rst_multi", multi,      0);
        check("rst_cnt",   press_cnt,  0);
        tick(2);
        rst_n = 1'b1;

        // Single key, ready held high: exact latency and one-cycle valid.
        key_in = 4'b0100; code_ready = 1'b1;
        tick(6);
        check("a_valid_e6", code_valid, 0);
        tick(1);
        check("a_valid_e7", code_valid, 1);
        check("a_code",     code,       2);
        check("a_multi",    multi,      0);
        check("a_cnt_pre",  press_cnt,  0);
        tick(1);
        check("a_valid_e8", code_valid, 0);
        check("a_cnt",      press_cnt,  1);
        key_in = 4'b0000;
        tick(8);

        // Two keys, consumer stalls; code must hold even when keys change.
        code_ready = 1'b0; key_in = 4'b1010;
        wait_valid(20, n);
        check("b_lat", n, 7);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (i == 10) key_in = 4'b0001;
            if (!(code_valid === 1'b1 && code === 2'd3 && multi === 1'b1)) bad++;
        end
        check("b_hold_bad", bad, 0);
        check("b_cnt_stall", press_cnt, 1);
        code_ready = 1'b1;
        tick(1);
        check("b_valid_after", code_valid, 0);
        check("b_cnt", press_cnt, 2);
        key_in = 4'b0000;
        tick(8);

        // Pattern changes mid-debounce: restart on the new snapshot.
        key_in = 4'b0100;
        tick(2);
        key_in = 4'b0110;
        tick(6);
        check("c_valid_e8", code_valid, 0);
        tick(1);
        check("c_valid_e9", code_valid, 1);
        check("c_code",     code,       2);
        check("c_multi",    multi,      1);
        tick(1);
        check("c_cnt", press_cnt, 3);
        key_in = 4'b0000;
        tick(8);

        // Short glitch is rejected; a following press sees full latency.
        key_in = 4'b0001;
        tick(2);
        key_in = 4'b0000;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (code_valid !== 1'b0) bad++;
        end
        check("d_glitch_valid", bad, 0);
        check("d_glitch_cnt", press_cnt, 3);
        key_in = 4'b0001;
        wait_valid(20, n);
        check("d_lat",   n,     7);
        check("d_code",  code,  0);
        check("d_multi", multi, 0);
        tick(1);
        check("d_cnt", press_cnt, 4);

        // Held key: a 3-cycle release is not enough, 4 cycles is.
        tick(4);
        key_in = 4'b0000;
        tick(3);
        key_in = 4'b0001;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (code_valid !== 1'b0) bad++;
        end
        check("e_short_rel_valid", bad, 0);
        check("e_short_rel_cnt", press_cnt, 4);
        key_in = 4'b0000;
        tick(4);
        key_in = 4'b0001;
        wait_valid(20, n);
        check("e_lat", n, 7);
        tick(1);
        check("e_cnt", press_cnt, 5);
        key_in = 4'b0000;
        tick(8);

        // Reset during PRESENT drops the code; held key is a fresh press.
        code_ready = 1'b0; key_in = 4'b1000;
        wait_valid(20, n);
        check("f_lat", n, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rst_valid", code_valid, 0);
        check("f_rst_cnt",   press_cnt,  0);
        check("f_rst_code",  code,       0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_valid(20, n);
        check("f_lat_post", n, 7);
        check("f_code", code, 3);
        check("f_cnt_pre", press_cnt, 0);
        code_ready = 1'b1;
        tick(1);
        check("f_cnt", press_cnt, 1);
        key_in = 4'b0000;
        tick(8);

        // 256 accepted presses from zero: counter wraps back to zero.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_cnt = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            key_in = 4'b0010;
            wait_valid(20, n);
            if (n != 7 || code !== 2'd1 || multi !== 1'b0) bad++;
            tick(1);
            exp_cnt = (exp_cnt + 1) & 255;
            if (press_cnt !== exp_cnt[7:0]) bad++;
            if (i == 254) check("g_cnt_255", press_cnt, 255);
            key_in = 4'b0000;
            tick(8);
        end
        check("g_loop_bad", bad, 0);
        check("g_cnt_wrap", press_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_encoder_4to2.md
KEY_ENCODER_4TO2 -- requirements
Module: key_encoder_4to2

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable sampled cycles required to accept a press or release; legal range 1..65535.
REQ-002 Port clk, input, 1, single clock; all flops rising-edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port key_in, input, 4, raw asynchronous key lines, active-high; one line per decoded position 0..3.
REQ-005 Port code_ready, input, 1, consumer accepts code when high with code_valid.
REQ-006 Port code_valid, output, 1, debounced encoded key available.
REQ-007 Port code, output, 2, index of highest active key line.
REQ-008 Port multi, output, 1, more than one key line was active in the accepted snapshot.
REQ-009 Port press_cnt, output, 8, count of completed handshakes.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer per bit; "sync" below means the synchronizer output.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, PRESENT, RELEASE.
REQ-012 IDLE: sync != 0 -> capture snapshot = sync, counter = 0, go DEBOUNCE; otherwise stay.
REQ-013 DEBOUNCE: sync == snapshot and counter == DEBOUNCE_CYCLES-1 -> go PRESENT; sync == snapshot otherwise -> counter+1.
REQ-014 DEBOUNCE: sync == 0 -> go IDLE; sync nonzero and != snapshot -> snapshot = sync, counter = 0, stay.
REQ-015 On DEBOUNCE->PRESENT, code SHALL load priority encode of snapshot (bit3 highest wins: 1xxx->3, 01xx->2, 001x->1, 0001->0) and multi SHALL load (popcount(snapshot) > 1).
REQ-016 PRESENT: code_valid = 1; code and multi SHALL stay constant until handshake regardless of key_in.
REQ-017 Handshake = code_valid && code_ready at a rising edge; on handshake go RELEASE, press_cnt+1 (wraps 255->0), counter = 0.
REQ-018 code_ready low in PRESENT SHALL hold the state indefinitely with no loss of code.
REQ-019 RELEASE: sync == 0 -> counter+1, reaching DEBOUNCE_CYCLES-1 -> IDLE; sync != 0 -> counter = 0, stay (no new press reported until full release).
REQ-020 code_valid SHALL be high only in PRESENT; code_ready SHALL be ignored in other states.
REQ-021 Latency: key_in set stable before edge 1 -> code_valid high after edge DEBOUNCE_CYCLES+3.
REQ-022 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, synchronizer flops 0, snapshot 0, counter 0, code_valid 0, code 0, multi 0, press_cnt 0.
REQ-024 Reset asserted mid-DEBOUNCE or mid-PRESENT SHALL discard the pending press; no handshake counted.
REQ-025 Reset deassertion SHALL take effect on the first rising edge after rst_n rises; keys held across reset are then treated as a new press.

Structure
REQ-026 Shared package key_enc_pkg SHALL hold the state enum (IDLE, DEBOUNCE, PRESENT, RELEASE) and the DEBOUNCE_CYCLES default constant.
REQ-027 Sub-module key_sync (parameterized-width 2-flop synchronizer with async active-low reset) SHALL be instantiated once for the 4 key lines.
REQ-028 Priority encode and popcount SHALL be combinational functions in key_enc_pkg.

Verification
REQ-029 DEBOUNCE_CYCLES=4, key_in=4'b0100 held, code_ready=1 -> code_valid high after edge 7 for one cycle, code=2, multi=0, press_cnt=1.
REQ-030 key_in=4'b1010, code_ready=0 for 20 cycles then 1 -> code_valid held 20+ cycles, code=3, multi=1 stable, one handshake, press_cnt=1.
REQ-031 key_in=4'b0001 pulsed 2 cycles then 0 -> no code_valid, FSM returns IDLE.
REQ-032 Key held after handshake, released 2 cycles, re-pressed -> no second code_valid until key 0 for 4 sampled cycles then new debounce.
REQ-033 rst_n pulsed low during PRESENT -> code_valid 0 immediately, press_cnt 0; key still held -> new code_valid 7 edges after rst_n release.
REQ-034 256 press/accept cycles with key_in=4'b0010 -> press_cnt wraps to 0, every code=1.
